// File: rtl/multi_timer.sv
// -----------------------------------------------------------------------------
// multi_timer
//   Multi-channel down-counting timer for the traffic light controller.
//   Each channel loads a duration on start and counts down once per
//   oneHz_enable strobe. It runs either one-shot, holding expiry until the
//   next start, or auto-reload, giving a 1-cycle expiry pulse each period.
//
// Optional feature macro: TIMER_PAUSE_EN
//   When this macro is defined, the module gains a per-channel pause input.
//   While pause[i] is high, ticks are ignored for channel i.
//
// Parameters
//   CHANNELS      number of independent channels (>= 1)
//   WIDTH         counter / duration width in bits (>= 2)
//
// Ports
//   clk           system clock, rising edge
//   Reset_Sync    synchronous reset, active-low
//   oneHz_enable  tick strobe; each high clk cycle is one tick
//   start         per-channel load strobe (level: reloads every cycle held)
//   mode          per-channel mode, 0 = one-shot, 1 = auto-reload (sampled on start)
//   Value         per-channel duration, ch i at Value[i*WIDTH +: WIDTH]
//   pause         (TIMER_PAUSE_EN only) per-channel tick mask
//   expired       per-channel expiry (level in one-shot, pulse in reload)
//   busy          per-channel counting indicator (RUN state)
//   remaining     per-channel current count, same slicing as Value
// -----------------------------------------------------------------------------
module multi_timer #(
   parameter int CHANNELS = 2,
   parameter int WIDTH    = 4
) (
   input  logic                      clk,
   input  logic                      Reset_Sync,
   input  logic                      oneHz_enable,
   input  logic [CHANNELS-1:0]       start,
   input  logic [CHANNELS-1:0]       mode,
   input  logic [CHANNELS*WIDTH-1:0] Value,
`ifdef TIMER_PAUSE_EN
   input  logic [CHANNELS-1:0]       pause,
`endif
   output logic [CHANNELS-1:0]       expired,
   output logic [CHANNELS-1:0]       busy,
   output logic [CHANNELS*WIDTH-1:0] remaining
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Per-channel qualified tick.
   logic [CHANNELS-1:0] tick_en;

`ifdef TIMER_PAUSE_EN
   assign tick_en = {CHANNELS{oneHz_enable}} & ~pause;
`else
   assign tick_en = {CHANNELS{oneHz_enable}};
`endif

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         state_t           state_reg;
         logic [WIDTH-1:0] cnt_reg;
         logic [WIDTH-1:0] reload_reg;
         logic             mode_reg;
         logic             expired_reg;
         logic [WIDTH-1:0] value_in;

         assign value_in = Value[gi*WIDTH +: WIDTH];

         always_ff @(posedge clk) begin
            if (!Reset_Sync) begin
               state_reg   <= ST_IDLE;
               cnt_reg     <= '0;
               reload_reg  <= '0;
               mode_reg    <= 1'b0;
               expired_reg <= 1'b0;
            end else if (start[gi]) begin
               // Start wins over a coincident tick: the count is loaded, not decremented.
               cnt_reg    <= value_in;
               reload_reg <= value_in;
               mode_reg   <= mode[gi];
               if (value_in == '0) begin
                  // A zero duration expires immediately. In reload mode a zero
                  // period makes no sense, so the channel falls back to IDLE
                  // after a single pulse.
                  expired_reg <= 1'b1;
                  state_reg   <= mode[gi] ? ST_IDLE : ST_DONE;
               end else begin
                  expired_reg <= 1'b0;
                  state_reg   <= ST_RUN;
               end
            end else begin
               case (state_reg)
                  ST_RUN: begin
                     // The reload pulse lasts one cycle unless re-asserted below.
                     expired_reg <= 1'b0;
                     if (tick_en[gi]) begin
                        if (cnt_reg > WIDTH'(1)) begin
                           cnt_reg <= cnt_reg - WIDTH'(1);
                        end else if (mode_reg) begin
                           cnt_reg     <= reload_reg;
                           expired_reg <= 1'b1;
                        end else begin
                           cnt_reg     <= '0;
                           expired_reg <= 1'b1;
                           state_reg   <= ST_DONE;
                        end
                     end
                  end
                  ST_DONE: begin
                     expired_reg <= 1'b1;
                  end
                  default: begin
                     expired_reg <= 1'b0;
                     state_reg   <= ST_IDLE;
                  end
               endcase
            end
         end

         assign expired[gi]                 = expired_reg;
         assign busy[gi]                    = (state_reg == ST_RUN);
         assign remaining[gi*WIDTH +: WIDTH] = cnt_reg;
      end
   endgenerate

endmodule
